piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//   Parallel-in serial-out shifter. Transmit-side counterpart of the 4-bit SIPO capture register.
//   Accepts a WIDTH-bit word over a valid/ready load port and emits it one bit per accepted beat.
//   The serial port uses a valid/ready pair. Default bit order is MSB-first. A SIPO clocked on
//   every out_valid&&out_ready beat therefore reassembles the original word after WIDTH beats.
// PARAMETERS
//   WIDTH      4   word width in bits; legal range >= 2
//   MSB_FIRST  1   1: bit WIDTH-1 is sent first; 0: bit 0 is sent first
// PORTS
//   clk         in   1      clock, rising edge
//   reset       in   1      reset, asynchronous, active-high
//   load_valid  in   1      load_data is valid
//   load_ready  out  1      serializer can accept a word this cycle
//   load_data   in   WIDTH  parallel word to send
//   out_ready   in   1      downstream accepts the current bit
//   out_valid   out  1      data_out holds a valid bit
//   data_out    out  1      current serial bit
//   out_first   out  1      data_out is the first bit of a word (qualified by out_valid)
//   out_last    out  1      data_out is the last bit of a word (qualified by out_valid)
// BEHAVIOUR
//   Reset values (held while reset=1):
//     - state=IDLE; shift register=0; bit counter=0
//     - out_valid=0, data_out=0, out_first=0, out_last=0
//     - load_ready=0 while reset=1; it rises in the first cycle after reset deasserts
//   States:
//     - IDLE: out_valid=0; load_ready=1
//       - On load_valid&&load_ready: capture load_data, set cnt=WIDTH-1, move to SHIFT
//     - SHIFT: out_valid=1; data_out = shreg[WIDTH-1] when MSB_FIRST=1, else shreg[0]
//       - out_first=1 when cnt==WIDTH-1; out_last=1 when cnt==0
//       - On beat (out_valid&&out_ready) with cnt!=0: shift toward the output end, fill 0, cnt-1
//       - On beat with cnt==0, no load: return to IDLE
//   Latency: word accepted at edge N -> its first bit is on data_out in cycle N+1.
//   Back-to-back words:
//     - load_ready = IDLE || (SHIFT && cnt==0 && out_ready); this path is combinational from out_ready
//     - Last beat and a load in the same cycle: the new word is captured, cnt=WIDTH-1, state stays SHIFT
//     - No idle bubble between words; a stream of words yields exactly WIDTH beats per word
//   Stall: while out_valid=1 && out_ready=0, data_out, out_first, out_last, cnt and shreg all hold.
//   load_valid in SHIFT with cnt!=0: ignored (load_ready=0); the upstream source must hold the word.
//   Reset mid-word: the word is abandoned; no partial word is resumed after reset.
//   Counter width: $clog2(WIDTH); cnt never wraps below 0.
// STRUCTURE
//   Shared package shift_pkg (constants only):
//     - state encodings ST_IDLE=1'b0, ST_SHIFT=1'b1
//     - default width constant SHIFT_W=4; also used by the SIPO and the benches
//   Single module; no sub-module required. Counter and shifter are small enough to stay inline.
// TESTING
//   1. Load 4'b1011, out_ready=1 -> data_out=1,0,1,1 in cycles N+1..N+4; out_first@N+1; out_last@N+4
//   2. MSB_FIRST=0, load 4'b1011 -> data_out=1,1,0,1; then out_valid=0 and load_ready=1
//   3. out_ready=0 for 3 cycles at bit 2 of 4'b0110 -> data_out holds 1, out_first=0, out_last=0; total 7 cycles to done
//   4. Words 4'hA then 4'h5, load_valid held -> 8 consecutive beats 1,0,1,0,0,1,0,1 with no out_valid gap
//   5. reset at bit 2 of 4'hF -> next cycle out_valid=0, data_out=0; load 4'h3 afterwards -> sends 0,0,1,1
//   6. Loopback into the 4-bit SIPO (clock-enabled on beat), random words x100 -> SIPO data_out equals each word after 4 beats

Source files
------------

// File: rtl/shift_pkg.sv
// Shared constants for the serial shift blocks (PISO transmitter, SIPO capture and their benches).
package shift_pkg;

    localparam int SHIFT_W = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/piso_serializer_if.sv
// Load-side and serial-side handshake bundle of the PISO serializer; slave is the serializer.
interface piso_serializer_if #(
    parameter int WIDTH = shift_pkg::SHIFT_W
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             out_ready;
    logic             out_valid;
    logic             data_out;
    logic             out_first;
    logic             out_last;

    modport master (
        output load_valid, load_data, out_ready,
        input  load_ready, out_valid, data_out, out_first, out_last
    );

    modport slave (
        input  load_valid, load_data, out_ready,
        output load_ready, out_valid, data_out, out_first, out_last
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter: word accepted at edge N shows its first bit in cycle N+1,
// one bit per out beat; a new word may load on the last beat so words stream without a bubble.
module piso_serializer
    import shift_pkg::*;
#(
    parameter int WIDTH     = SHIFT_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    piso_serializer_if.slave bus
);
    localparam int               CNT_W   = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WIDTH - 1);

    state_e           state;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] cnt;

    logic shifting;
    logic cnt_zero;
    logic beat;
    logic load_fire;
    logic out_bit;

    assign shifting  = (state == ST_SHIFT);
    assign cnt_zero  = (cnt == '0);
    assign beat      = shifting && bus.out_ready;
    // Ready is combinational from out_ready so the next word can replace the last bit in place.
    assign bus.load_ready = !reset && (!shifting || (cnt_zero && bus.out_ready));
    assign load_fire = bus.load_valid && bus.load_ready;
    assign out_bit   = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else if (load_fire) begin
            state <= ST_SHIFT;
            shreg <= bus.load_data;
            cnt   <= CNT_TOP;
        end else if (beat) begin
            if (!cnt_zero) begin
                shreg <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
                cnt   <= cnt - 1'b1;
            end else begin
                state <= ST_IDLE;
            end
        end
    end

    // Outputs are decoded only from registered state, so a stall holds them unchanged.
    assign bus.out_valid = shifting;
    assign bus.data_out  = shifting && out_bit;
    assign bus.out_first = shifting && (cnt == CNT_TOP);
    assign bus.out_last  = shifting && cnt_zero;

endmodule

// File: tb/tb_piso_serializer.sv
// Drives an MSB-first and an LSB-first serializer in lockstep against a bits-remaining word model.
module tb_piso_serializer;
    import shift_pkg::*;

    localparam int W = SHIFT_W;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    piso_serializer_if #(.WIDTH(W)) ifa ();
    piso_serializer_if #(.WIDTH(W)) ifb ();

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa.slave)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: bits still to send of the word in flight (0 = idle) and that word.
    int           rem [2];
    logic [W-1:0] word [2];
    logic [W-1:0] sipo;
    logic [W-1:0] sent_q [$];
    int           vld_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic lv, input logic [W-1:0] ld, input logic ordy);
        ifa.load_valid = lv;  ifa.load_data = ld;  ifa.out_ready = ordy;
        ifb.load_valid = lv;  ifb.load_data = ld;  ifb.out_ready = ordy;
    endtask

    // Called at posedge+1: drive, check at the falling edge, advance the model, move to next posedge+1.
    task automatic cycle(input logic lv, input logic [W-1:0] ld, input logic ordy);
        logic ov [2];
        logic lr [2];
        logic dd [2];
        logic ff [2];
        logic ll [2];
        logic exp_rdy;
        int   idx;
        string nm;
        drive(lv, ld, ordy);
        #4;
        ov[0] = ifa.out_valid; lr[0] = ifa.load_ready; dd[0] = ifa.data_out;
        ff[0] = ifa.out_first; ll[0] = ifa.out_last;
        ov[1] = ifb.out_valid; lr[1] = ifb.load_ready; dd[1] = ifb.data_out;
        ff[1] = ifb.out_first; ll[1] = ifb.out_last;
        for (int k = 0; k < 2; k++) begin
            nm = (k == 0) ? "msb" : "lsb";
            exp_rdy = (rem[k] == 0) || (rem[k] == 1 && ordy);
            check({nm, "_load_ready"}, 32'(lr[k]), 32'(exp_rdy));
            check({nm, "_out_valid"}, 32'(ov[k]), 32'(rem[k] != 0));
            if (rem[k] != 0) begin
                idx = (k == 0) ? rem[k] - 1 : W - rem[k];
                check({nm, "_data_out"}, 32'(dd[k]), 32'(word[k][idx]));
                check({nm, "_first"}, 32'(ff[k]), 32'(rem[k] == W));
                check({nm, "_last"}, 32'(ll[k]), 32'(rem[k] == 1));
            end
        end
        if (rem[0] != 0 && ordy) begin
            sipo = {sipo[W-2:0], ifa.data_out};
            if (rem[0] == 1) begin
                check("sipo_pending", 32'(sent_q.size()), 32'd1);
                if (sent_q.size() != 0) check("sipo_word", 32'(sipo), 32'(sent_q.pop_front()));
            end
        end
        for (int k = 0; k < 2; k++) begin
            exp_rdy = (rem[k] == 0) || (rem[k] == 1 && ordy);
            if (lv && exp_rdy) begin
                rem[k]  = W;
                word[k] = ld;
                if (k == 0) sent_q.push_back(ld);
            end else if (rem[k] != 0 && ordy) begin
                rem[k]--;
            end
        end
        if (ov[0]) vld_cnt++;
        @(posedge clk);
        #1;
    endtask

    // Reset asserted mid-cycle: outputs must clear at once and the word in flight is dropped.
    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, '0, 1'b0);
        #4;
        check("rst_out_valid", 32'({ifa.out_valid, ifb.out_valid}), 32'd0);
        check("rst_data_out", 32'({ifa.data_out, ifb.data_out}), 32'd0);
        check("rst_first_last", 32'({ifa.out_first, ifa.out_last, ifb.out_first, ifb.out_last}), 32'd0);
        check("rst_load_ready", 32'({ifa.load_ready, ifb.load_ready}), 32'd0);
        rem[0] = 0;
        rem[1] = 0;
        sipo   = '0;
        sent_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic         r_lv;
    logic [W-1:0] r_ld;
    logic         r_rdy;
    logic         fired;

    initial begin
        drive(1'b0, '0, 1'b0);
        rem[0] = 0;  rem[1] = 0;
        word[0] = '0; word[1] = '0;
        sipo = '0;
        vld_cnt = 0;
        @(posedge clk);
        #1;
        do_reset();

        // Single word, continuous ready; trailing idle cycles confirm the return to IDLE.
        cycle(1'b1, 4'b1011, 1'b1);
        repeat (4) cycle(1'b0, '0, 1'b1);
        repeat (2) cycle(1'b0, '0, 1'b1);

        // Stall at the second bit for three cycles.
        vld_cnt = 0;
        cycle(1'b1, 4'b0110, 1'b1);
        cycle(1'b0, '0, 1'b1);
        repeat (3) cycle(1'b0, '0, 1'b0);
        repeat (3) cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        check("stall_valid_cycles", 32'(vld_cnt), 32'd7);

        // Back-to-back words with load_valid held.
        vld_cnt = 0;
        cycle(1'b1, 4'hA, 1'b1);
        repeat (4) cycle(1'b1, 4'h5, 1'b1);
        repeat (4) cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        check("b2b_valid_cycles", 32'(vld_cnt), 32'd8);

        // Reset in the middle of 4'hF, then a clean word.
        cycle(1'b1, 4'hF, 1'b1);
        cycle(1'b0, '0, 1'b1);
        do_reset();
        cycle(1'b1, 4'h3, 1'b1);
        repeat (5) cycle(1'b0, '0, 1'b1);

        // Random traffic; the source holds a word until it is accepted.
        r_lv = 1'b0;
        r_ld = '0;
        repeat (600) begin
            r_rdy = ($urandom_range(0, 3) != 0);
            fired = r_lv && ((rem[0] == 0) || (rem[0] == 1 && r_rdy));
            cycle(r_lv, r_ld, r_rdy);
            if (fired || !r_lv) begin
                r_lv = ($urandom_range(0, 2) != 0);
                r_ld = W'($urandom);
            end
        end
        repeat (8) cycle(1'b0, '0, 1'b1);
        check("words_drained", 32'(sent_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
